bp_update_fifo: RTL and testbench

Buffers resolved branch outcomes from the EX stage and drains them into the gshare predictor's PHT/GHR update port, one entry per cycle. It sits between EX-stage branch resolution and the predictor's `wen`/`windex`/`take` inputs. It decouples resolution bursts from predictor writes. It also flags when a prediction lookup hits an index that still has a pending update.

---
 rtl/bp_update_fifo.sv | 108 ++++++++++
 tb/tb_bp_update_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_fifo.sv
// Branch-update FIFO between EX-stage resolution and the gshare PHT/GHR write port.
// Drains one registered update per cycle unless held; flags lookups that hit a pending update.
module bp_update_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [IDX_W-1:0]           in_index,
  input  logic                       in_take,
  output logic                       in_ready,
  input  logic                       upd_hold,
  output logic                       out_wen,
  output logic [IDX_W-1:0]           out_windex,
  output logic                       out_take,
  input  logic [IDX_W-1:0]           lookup_index,
  output logic                       pending_hit,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             out_wen_q, out_wen_d;
  logic [IDX_W-1:0] out_windex_q, out_windex_d;
  logic             out_take_q, out_take_d;

  logic [IDX_W-1:0] mem_idx_q  [DEPTH];
  logic             mem_take_q [DEPTH];

  logic full, empty, enq, deq;
  logic [PW-1:0] occ;

  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    occ   = wptr_q - rptr_q;
    // Readiness comes only from registered pointers: a same-cycle dequeue never frees a slot for this cycle's enqueue.
    enq   = in_valid && !full;
    deq   = !empty && !upd_hold;
  end

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    out_wen_d    = 1'b0;
    out_windex_d = out_windex_q;
    out_take_d   = out_take_q;
    if (enq) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (deq) begin
      rptr_d       = rptr_q + 1'b1;
      out_wen_d    = 1'b1;
      out_windex_d = mem_idx_q[rptr_q[AW-1:0]];
      out_take_d   = mem_take_q[rptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      out_wen_q    <= 1'b0;
      out_windex_q <= '0;
      out_take_q   <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      out_wen_q    <= out_wen_d;
      out_windex_q <= out_windex_d;
      out_take_q   <= out_take_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_idx_q[wptr_q[AW-1:0]]  <= in_index;
      mem_take_q[wptr_q[AW-1:0]] <= in_take;
    end
  end

  logic [AW-1:0] slot;
  logic          hit;

  always_comb begin
    slot = '0;
    hit  = out_wen_q && (out_windex_q == lookup_index);
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = rptr_q[AW-1:0] + AW'(k);
      if ((PW'(k) < occ) && (mem_idx_q[slot] == lookup_index)) begin
        hit = 1'b1;
      end
    end
  end

  assign in_ready    = !full;
  assign out_wen     = out_wen_q;
  assign out_windex  = out_windex_q;
  assign out_take    = out_take_q;
  assign pending_hit = hit;
  assign count       = occ;

endmodule

// File: tb/tb_bp_update_fifo.sv
// Self-checking bench for bp_update_fifo: directed test-plan scenarios plus
// randomized traffic, checked against a queue-based reference model.
module tb_bp_update_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDX_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [IDX_W-1:0] in_index;
  logic             in_take;
  logic             in_ready;
  logic             upd_hold;
  logic             out_wen;
  logic [IDX_W-1:0] out_windex;
  logic             out_take;
  logic [IDX_W-1:0] lookup_index;
  logic             pending_hit;
  logic [2:0]       count;

  bp_update_fifo #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_index(in_index), .in_take(in_take), .in_ready(in_ready),
    .upd_hold(upd_hold),
    .out_wen(out_wen), .out_windex(out_windex), .out_take(out_take),
    .lookup_index(lookup_index), .pending_hit(pending_hit), .count(count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of pending {index,take} plus the expected output registers.
  typedef struct { logic [IDX_W-1:0] idx; logic tk; } ent_t;
  ent_t             q[$];
  logic             m_wen;
  logic [IDX_W-1:0] m_idx;
  logic             m_tk;

  function automatic logic model_hit(input logic [IDX_W-1:0] li);
    logic h;
    h = m_wen && (m_idx == li);
    foreach (q[i]) if (q[i].idx == li) h = 1'b1;
    return h;
  endfunction

  task automatic model_edge();
    bit was_full;
    if (reset) begin
      q.delete();
      m_wen = 1'b0; m_idx = '0; m_tk = 1'b0;
      return;
    end
    was_full = (q.size() == DEPTH);
    if (q.size() > 0 && !upd_hold) begin
      m_wen = 1'b1; m_idx = q[0].idx; m_tk = q[0].tk;
      void'(q.pop_front());
    end else begin
      m_wen = 1'b0;
    end
    if (in_valid && !was_full) q.push_back('{idx: in_index, tk: in_take});
  endtask

  task automatic check_all(input string tag);
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
    check({tag, "_wen"}, 32'(out_wen), 32'(m_wen));
    check({tag, "_windex"}, 32'(out_windex), 32'(m_idx));
    check({tag, "_take"}, 32'(out_take), 32'(m_tk));
    check({tag, "_phit"}, 32'(pending_hit), 32'(model_hit(lookup_index)));
  endtask

  // One clock: inputs already driven; model and DUT both advance on the edge, sample #1 later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [IDX_W-1:0] idx, input logic tk, input logic hold);
    in_valid = v; in_index = idx; in_take = tk; upd_hold = hold;
  endtask

  task automatic do_reset(input int unsigned n);
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (n) tick("rst");
    reset = 1'b0;
  endtask

  int unsigned wen_seen;
  int unsigned max_cnt;
  logic [IDX_W-1:0] order [$];

  initial begin
    reset = 1'b1; lookup_index = '0;
    drive(1'b0, '0, 1'b0, 1'b0);
    m_wen = 1'b0; m_idx = '0; m_tk = 1'b0;

    // 1: reset then single entry
    do_reset(2);
    check("t1_rst_ready", 32'(in_ready), 32'd1);
    check("t1_rst_count", 32'(count), 32'd0);
    check("t1_rst_phit", 32'(pending_hit), 32'd0);
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    tick("t1a");
    check("t1_cnt1", 32'(count), 32'd1);
    check("t1_nowen", 32'(out_wen), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick("t1b");
    check("t1_wen", 32'(out_wen), 32'd1);
    check("t1_idx", 32'(out_windex), 32'h5A);
    check("t1_take", 32'(out_take), 32'd1);
    check("t1_cnt0", 32'(count), 32'd0);
    tick("t1c");
    check("t1_wen_off", 32'(out_wen), 32'd0);
    check("t1_idx_hold", 32'(out_windex), 32'h5A);

    // 2: fill to full, drop a fifth, drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), i[0], 1'b1);
      tick("t2fill");
    end
    check("t2_full_cnt", 32'(count), 32'd4);
    check("t2_full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 8'hFF, 1'b1, 1'b1);
    tick("t2drop");
    check("t2_drop_cnt", 32'(count), 32'd4);
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick("t2drain");
      check("t2_drain_wen", 32'(out_wen), 32'd1);
      check("t2_drain_idx", 32'(out_windex), 32'(i));
    end
    tick("t2after");
    check("t2_no_ff", 32'(out_wen), 32'd0);

    // 3: streaming wrap-around
    wen_seen = 0; max_cnt = 0; order.delete();
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      else        drive(1'b0, '0, 1'b0, 1'b0);
      tick("t3");
      if (32'(count) > max_cnt) max_cnt = 32'(count);
      if (out_wen) order.push_back(out_windex);
    end
    check("t3_max_cnt", max_cnt, 32'd1);
    check("t3_n_out", 32'(order.size()), 32'd10);
    foreach (order[i]) check("t3_order", 32'(order[i]), 32'(8'h40 + i));

    // 4: hold mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h60 + i), 1'b1, 1'b1);
      tick("t4fill");
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick("t4first");
    check("t4_first", 32'(out_windex), 32'h60);
    drive(1'b0, '0, 1'b0, 1'b1);
    tick("t4hold1");
    check("t4_hold1_wen", 32'(out_wen), 32'd0);
    tick("t4hold2");
    check("t4_hold2_wen", 32'(out_wen), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick("t4r1");
    check("t4_r1", 32'(out_windex), 32'h61);
    tick("t4r2");
    check("t4_r2", 32'(out_windex), 32'h62);
    check("t4_r2_wen", 32'(out_wen), 32'd1);
    tick("t4idle");

    // 5: pending hit
    drive(1'b1, 8'h33, 1'b0, 1'b1);
    tick("t5q");
    drive(1'b0, '0, 1'b0, 1'b1);
    lookup_index = 8'h33; #1;
    check("t5_hit33", 32'(pending_hit), 32'd1);
    lookup_index = 8'h34; #1;
    check("t5_miss34", 32'(pending_hit), 32'd0);
    lookup_index = 8'h33;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick("t5rel");
    check("t5_wen_hit", 32'(pending_hit), 32'd1);
    check("t5_wen", 32'(out_wen), 32'd1);
    tick("t5after");
    check("t5_after_hit", 32'(pending_hit), 32'd0);

    // 6: reset while non-empty
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b1);
      tick("t6fill");
    end
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick("t6rst");
    reset = 1'b0;
    check("t6_cnt", 32'(count), 32'd0);
    check("t6_wen", 32'(out_wen), 32'd0);
    check("t6_ready", 32'(in_ready), 32'd1);
    wen_seen = 0;
    repeat (4) begin
      tick("t6post");
      if (out_wen) wen_seen++;
    end
    check("t6_no_stale", wen_seen, 32'd0);

    // Randomized traffic with a narrow index range so lookups hit often
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 99) < 60, 8'($urandom_range(0, 7)), 1'($urandom),
            $urandom_range(0, 99) < 35);
      lookup_index = 8'($urandom_range(0, 7));
      tick("rnd");
      lookup_index = 8'($urandom_range(0, 7)); #1;
      check("rnd_phit2", 32'(pending_hit), 32'(model_hit(lookup_index)));
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
